seg_scan_controller: RTL and testbench

Sequencing controller for the seven-segment counter display. It accepts a binary count over a valid/ready handshake and converts it to BCD one digit per cycle, time-sharing a single divide-by-10 unit. It commits the digits atomically to display registers and drives the multiplexed digit-select scan with programmable dwell and anti-ghost blanking. It sits between the cycle counter and the external BCD-to-7-segment decoder and anode drivers.

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_scan_controller_if.sv | 13 +
 rtl/seg_scan_controller_divmod10.sv | 13 +
 rtl/seg_scan_controller.sv | 136 +++++++++++++
 tb/tb_seg_scan_controller.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the conversion FSM state encoding and the blank BCD code.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int SEG_DIGITS_DEFAULT = 4;

endpackage

// File: rtl/seg_scan_controller_if.sv
// Valid/ready channel carrying a binary count into the scan controller.
interface seg_scan_controller_if #(
  parameter int VALUE_WIDTH = 16
);

  logic [VALUE_WIDTH-1:0] value;
  logic                   value_valid;
  logic                   value_ready;

  modport master (output value, output value_valid, input value_ready);
  modport slave  (input value, input value_valid, output value_ready);

endinterface

// File: rtl/seg_scan_controller_divmod10.sv
// Combinational divide-by-10, shared by every digit step of the conversion.
module divmod10 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] dividend_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [3:0]       remainder_o
);

  assign quotient_o  = dividend_i / WIDTH'(10);
  assign remainder_o = 4'(dividend_i % WIDTH'(10));

endmodule

// File: rtl/seg_scan_controller.sv
// Binary-to-BCD sequencer with atomic display commit and a multiplexed
// digit scan featuring programmable dwell and anti-ghost blanking.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGITS      = SEG_DIGITS_DEFAULT,
  parameter int VALUE_WIDTH = 16,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_scan_controller_if.slave   vif,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [3:0]             blank,
  input  logic                   lz_en,
  output logic [DIGITS-1:0]      digit_sel,
  output logic [3:0]             bcd_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IW = $clog2(DIGITS);

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] work_q, work_d, quot;
  logic [3:0]             rem;
  logic [IW-1:0]          idx_q, idx_d;
  logic [3:0]             shadow_q [DIGITS];
  logic [3:0]             shadow_d [DIGITS];
  logic [3:0]             disp_q [DIGITS];
  logic [3:0]             disp_d [DIGITS];
  logic                   overflow_q, overflow_d;

  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d, slotLast;
  logic [IW-1:0]          scanIdx_q, scanIdx_d, msd;
  logic [DIGITS-1:0]      digitSel_q, digitSel_d;
  logic [3:0]             bcd_q, bcd_d, code;

  divmod10 #(.WIDTH(VALUE_WIDTH)) uDiv (
    .dividend_i  (work_q),
    .quotient_o  (quot),
    .remainder_o (rem)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (vif.value_valid) begin
          work_d  = vif.value;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shadow_d[idx_q] = rem;
        work_d          = quot;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        // Leftover quotient means the value did not fit; show all nines.
        overflow_d = (work_q != '0);
        for (int i = 0; i < DIGITS; i++) disp_d[i] = overflow_d ? 4'd9 : shadow_q[i];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= 4'd0;
        disp_q[i]   <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    slotLast  = (dwell == '0) ? '0 : dwell - 1'b1;
    cnt_d     = cnt_q + 1'b1;
    scanIdx_d = scanIdx_q;
    // A >= compare lets a shortened dwell end the current slot at once.
    if (cnt_q >= slotLast) begin
      cnt_d     = '0;
      scanIdx_d = (scanIdx_q == IW'(DIGITS - 1)) ? '0 : scanIdx_q + 1'b1;
    end
    msd = '0;
    for (int i = 1; i < DIGITS; i++) if (disp_q[i] != 4'd0) msd = IW'(i);
    code = (lz_en && (scanIdx_q > msd)) ? BCD_BLANK : disp_q[scanIdx_q];
    digitSel_d = '0;
    bcd_d      = BCD_BLANK;
    if (cnt_q >= DWELL_WIDTH'(blank)) begin
      digitSel_d = DIGITS'(1) << scanIdx_q;
      bcd_d      = code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      scanIdx_q  <= '0;
      digitSel_q <= '0;
      bcd_q      <= BCD_BLANK;
    end else begin
      cnt_q      <= cnt_d;
      scanIdx_q  <= scanIdx_d;
      digitSel_q <= digitSel_d;
      bcd_q      <= bcd_d;
    end
  end

  assign vif.value_ready = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign overflow        = overflow_q;
  assign digit_sel       = digitSel_q;
  assign bcd_out         = bcd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with DIGITS=4: conversion, overflow,
// leading-zero suppression, scan timing, atomic commit and reset behaviour.
module tb_seg_scan_controller;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dwell;
  logic [3:0] blank;
  logic       lz_en;
  logic [3:0] digit_sel;
  logic [3:0] bcd_out;
  logic       overflow;
  logic       busy;
  int         errors = 0;
  int         checks = 0;

  seg_scan_controller_if #(.VALUE_WIDTH(16)) vif ();

  seg_scan_controller #(.DIGITS(4), .VALUE_WIDTH(16), .DWELL_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .vif       (vif),
    .dwell     (dwell),
    .blank     (blank),
    .lz_en     (lz_en),
    .digit_sel (digit_sel),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the release edge, so the next edge is the first free-running one.
  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic convertValue(input logic [15:0] v);
    vif.value       = v;
    vif.value_valid = 1'b1;
    tick();
    vif.value_valid = 1'b0;
    repeat (5) tick();
  endtask

  // Scans at one cycle per digit and gathers the four shown codes, digit 3 in the top nibble.
  task automatic captureDisplay(output logic [15:0] d);
    dwell = 8'd1;
    blank = 4'd0;
    d     = 16'hEEEE;
    tick();
    tick();
    repeat (4) begin
      tick();
      case (digit_sel)
        4'b0001: d[3:0]   = bcd_out;
        4'b0010: d[7:4]   = bcd_out;
        4'b0100: d[11:8]  = bcd_out;
        4'b1000: d[15:12] = bcd_out;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    #2;
    checks++; if (vif.value_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", vif.value_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (digit_sel !== 4'b0000) begin errors++; $display("[TB] FAIL reset_sel: got %b want 0000", digit_sel); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("[TB] FAIL reset_bcd: got %h want f", bcd_out); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    captureDisplay(d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_display: got %h want 0000", d); end
  endtask

  task automatic test_scan();
    logic [3:0] expSlot [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    logic [3:0] expFast [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] seen;
    logic       badBcd;
    lz_en = 1'b0;
    dwell = 8'd3;
    blank = 4'd1;
    doReset();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (digit_sel !== expSlot[i]) begin errors++; $display("[TB] FAIL scan_slot_sel[%0d]: got %b want %b", i, digit_sel, expSlot[i]); end
      checks++; if (bcd_out !== ((expSlot[i] == 4'h0) ? 4'hF : 4'h0)) begin errors++; $display("[TB] FAIL scan_slot_bcd[%0d]: got %h want %h", i, bcd_out, (expSlot[i] == 4'h0) ? 4'hF : 4'h0); end
    end
    dwell = 8'd0;
    blank = 4'd0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (digit_sel !== expFast[i]) begin errors++; $display("[TB] FAIL scan_dwell0[%0d]: got %b want %b", i, digit_sel, expFast[i]); end
    end
    dwell = 8'd3;
    blank = 4'd5;
    tick();
    tick();
    seen   = 4'b0000;
    badBcd = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | digit_sel;
      if (bcd_out !== 4'hF) badBcd = 1'b1;
    end
    checks++; if (seen !== 4'b0000) begin errors++; $display("[TB] FAIL scan_dark_sel: got %b want 0000", seen); end
    checks++; if (badBcd !== 1'b0) begin errors++; $display("[TB] FAIL scan_dark_bcd: got %b want 0", badBcd); end
    dwell = 8'd8;
    blank = 4'd0;
    doReset();
    repeat (4) tick();
    dwell = 8'd2;
    tick();
    checks++; if (digit_sel !== 4'b0001) begin errors++; $display("[TB] FAIL scan_shrink_a: got %b want 0001", digit_sel); end
    tick();
    checks++; if (digit_sel !== 4'b0010) begin errors++; $display("[TB] FAIL scan_shrink_b: got %b want 0010", digit_sel); end
  endtask

  task automatic test_convert();
    logic [15:0] d;
    int          low;
    vif.value       = 16'd1234;
    vif.value_valid = 1'b1;
    tick();
    vif.value_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL conv_busy: got %b want 1", busy); end
    low = 0;
    while (vif.value_ready === 1'b0 && low < 20) begin
      low++;
      tick();
    end
    checks++; if (low != 5) begin errors++; $display("[TB] FAIL conv_ready_low: got %0d want 5", low); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL conv_overflow: got %b want 0", overflow); end
    captureDisplay(d);
    checks++; if (d !== 16'h1234) begin errors++; $display("[TB] FAIL conv_1234: got %h want 1234", d); end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    convertValue(16'd12345);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
    captureDisplay(d);
    checks++; if (d !== 16'h9999) begin errors++; $display("[TB] FAIL ovf_nines: got %h want 9999", d); end
    convertValue(16'd42);
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow); end
    captureDisplay(d);
    checks++; if (d !== 16'h0042) begin errors++; $display("[TB] FAIL ovf_42: got %h want 0042", d); end
    lz_en = 1'b1;
    captureDisplay(d);
    checks++; if (d !== 16'hFF42) begin errors++; $display("[TB] FAIL ovf_42_lz: got %h want ff42", d); end
    lz_en = 1'b0;
  endtask

  task automatic test_lz();
    logic [15:0] d;
    lz_en = 1'b1;
    convertValue(16'd0);
    captureDisplay(d);
    checks++; if (d !== 16'hFFF0) begin errors++; $display("[TB] FAIL lz_zero: got %h want fff0", d); end
    convertValue(16'd1000);
    captureDisplay(d);
    checks++; if (d !== 16'h1000) begin errors++; $display("[TB] FAIL lz_1000: got %h want 1000", d); end
    convertValue(16'd305);
    captureDisplay(d);
    checks++; if (d !== 16'hF305) begin errors++; $display("[TB] FAIL lz_305: got %h want f305", d); end
    lz_en = 1'b0;
  endtask

  task automatic test_atomic();
    logic [15:0] d;
    logic [15:0] newVal;
    logic [3:0]  expDigit;
    int          idx;
    convertValue(16'd9999);
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL atomic_9999_ovf: got %b want 0", overflow); end
    captureDisplay(d);
    checks++; if (d !== 16'h9999) begin errors++; $display("[TB] FAIL atomic_9999: got %h want 9999", d); end
    newVal          = 16'h1000;
    vif.value       = 16'd1000;
    vif.value_valid = 1'b1;
    // Registered outputs show the old digits through E5 and the new ones from E6 on.
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) vif.value_valid = 1'b0;
      case (digit_sel)
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        4'b1000: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) expDigit = 4'hE;
      else if (k <= 5) expDigit = 4'd9;
      else expDigit = newVal[idx*4 +: 4];
      checks++; if (bcd_out !== expDigit) begin errors++; $display("[TB] FAIL atomic_step[%0d]: got %h want %h", k, bcd_out, expDigit); end
    end
  endtask

  task automatic test_reset_mid_conversion();
    logic [15:0] d;
    convertValue(16'd10000);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ovf_set: got %b want 1", overflow); end
    captureDisplay(d);
    checks++; if (d !== 16'h9999) begin errors++; $display("[TB] FAIL midrst_10000: got %h want 9999", d); end
    vif.value       = 16'd5678;
    vif.value_valid = 1'b1;
    tick();
    vif.value_valid = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    checks++; if (digit_sel !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_sel: got %b want 0000", digit_sel); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("[TB] FAIL midrst_bcd: got %h want f", bcd_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf: got %b want 0", overflow); end
    checks++; if (vif.value_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b want 1", vif.value_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    captureDisplay(d);
    checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_display: got %h want 0000", d); end
    convertValue(16'd7);
    captureDisplay(d);
    checks++; if (d !== 16'h0007) begin errors++; $display("[TB] FAIL midrst_7: got %h want 0007", d); end
    lz_en = 1'b1;
    captureDisplay(d);
    checks++; if (d !== 16'hFFF7) begin errors++; $display("[TB] FAIL midrst_7_lz: got %h want fff7", d); end
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    vif.value       = 16'd21;
    vif.value_valid = 1'b1;
    tick();
    vif.value = 16'd87;
    repeat (4) tick();
    checks++; if (vif.value_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_e4: got %b want 0", vif.value_ready); end
    tick();
    checks++; if (vif.value_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_e5: got %b want 1", vif.value_ready); end
    tick();
    checks++; if (vif.value_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept_e6: got %b want 0", vif.value_ready); end
    vif.value_valid = 1'b0;
    repeat (5) tick();
    checks++; if (vif.value_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle: got %b want 1", vif.value_ready); end
    captureDisplay(d);
    checks++; if (d !== 16'h0087) begin errors++; $display("[TB] FAIL b2b_87: got %h want 0087", d); end
  endtask

  initial begin
    rst             = 1'b1;
    vif.value       = 16'd0;
    vif.value_valid = 1'b0;
    dwell           = 8'd1;
    blank           = 4'd0;
    lz_en           = 1'b0;
    test_reset();
    test_scan();
    test_convert();
    test_overflow();
    test_lz();
    test_atomic();
    test_reset_mid_conversion();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
